dmem_mmio: RTL

Data-side memory subsystem for the single-cycle RISC-V core. Consumes the datapath's `ALUResult` (address), `WriteData` and the controller's `MemWrite`, and returns `ReadData` to the result mux in the same cycle. Decodes a word-addressed data RAM plus a small memory-mapped register bank: LED output register and a prescaled 32-bit timer with compare match and a sticky interrupt flag.

---
 rtl/mmio_pkg.sv | 29 ++
 rtl/dmem_mmio_if.sv | 29 ++
 rtl/mmio_timer.sv | 82 ++++++++
 rtl/dmem_mmio.sv | 108 ++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mmio_pkg
// Description : Address map and STATUS bit layout for the data-side MMIO bank.
// Revision    : 1.0 - initial release
// ============================================================================
package mmio_pkg;

    localparam logic [31:0] LED_ADR    = 32'hFFFF_0000;
    localparam logic [31:0] COUNT_ADR  = 32'hFFFF_0004;
    localparam logic [31:0] CMP_ADR    = 32'hFFFF_0008;
    localparam logic [31:0] STATUS_ADR = 32'hFFFF_000C;

    localparam int ST_MATCH = 0;
    localparam int ST_EN    = 1;

    localparam logic [31:0] CMP_RESET = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        SEL_NONE   = 3'd0,
        SEL_RAM    = 3'd1,
        SEL_LED    = 3'd2,
        SEL_COUNT  = 3'd3,
        SEL_CMP    = 3'd4,
        SEL_STATUS = 3'd5
    } sel_e;

endpackage
`default_nettype wire

// File: rtl/dmem_mmio_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_mmio_if
// Description : Single-cycle data bus between the core datapath and dmem_mmio.
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_mmio_if;

    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;

    modport master (
        output MemWrite,
        output DataAdr,
        output WriteData,
        input  ReadData
    );

    modport slave (
        input  MemWrite,
        input  DataAdr,
        input  WriteData,
        output ReadData
    );

endinterface
`default_nettype wire

// File: rtl/mmio_timer.sv
`default_nettype none
// ============================================================================
// Module      : mmio_timer
// Description : Prescaled 32-bit timer with compare value and sticky match flag.
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_timer
    import mmio_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        we_count,
    input  wire logic        we_cmp,
    input  wire logic        we_status,
    input  wire logic [31:0] wdata,
    output logic      [31:0] count,
    output logic      [31:0] cmp,
    output logic             en,
    output logic             match
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] C_PRE_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] r_pre;
    logic [31:0]   r_count;
    logic [31:0]   r_cmp;
    logic          r_en;
    logic          r_match;

    logic          w_tick;
    logic [31:0]   w_count_inc;
    logic          w_match_set;
    logic          w_match_clr;

    assign w_tick      = r_en && (r_pre == C_PRE_LAST);
    assign w_count_inc = r_count + 32'd1;
    // A COUNT load suppresses both the increment and the compare for that edge.
    assign w_match_set = w_tick && !we_count && (w_count_inc == r_cmp);
    assign w_match_clr = we_status && wdata[ST_MATCH];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pre   <= '0;
            r_count <= '0;
            r_cmp   <= CMP_RESET;
            r_en    <= 1'b0;
            r_match <= 1'b0;
        end else begin
            if (!r_en || we_count || w_tick) begin
                r_pre <= '0;
            end else begin
                r_pre <= r_pre + PW'(1);
            end

            if (we_count) begin
                r_count <= wdata;
            end else if (w_tick) begin
                r_count <= w_count_inc;
            end

            if (we_cmp) begin
                r_cmp <= wdata;
            end

            if (we_status) begin
                r_en <= wdata[ST_EN];
            end

            r_match <= w_match_set || (r_match && !w_match_clr);
        end
    end

    assign count = r_count;
    assign cmp   = r_cmp;
    assign en    = r_en;
    assign match = r_match;

endmodule
`default_nettype wire

// File: rtl/dmem_mmio.sv
`default_nettype none
// ============================================================================
// Module      : dmem_mmio
// Description : Data RAM plus LED and timer registers with combinational reads.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_mmio
    import mmio_pkg::*;
#(
    parameter int RAM_WORDS = 64,
    parameter int PRESCALE  = 1
) (
    input  wire logic       clk,
    input  wire logic       reset,
    dmem_mmio_if.slave      bus,
    output logic      [7:0] Leds,
    output logic            TimerIrq
);

    localparam int AW = $clog2(RAM_WORDS) + 2;

    logic [31:0]   r_ram [RAM_WORDS];
    logic [7:0]    r_led;

    sel_e          w_sel;
    logic [31:0]   w_word_adr;
    logic [AW-3:0] w_ram_idx;
    logic          w_wr;
    logic [31:0]   w_count;
    logic [31:0]   w_cmp;
    logic          w_en;
    logic          w_match;
    logic [31:0]   w_status;
    logic          w_unused_adr;

    assign w_word_adr   = {bus.DataAdr[31:2], 2'b00};
    assign w_ram_idx    = bus.DataAdr[AW-1:2];
    assign w_wr         = bus.MemWrite && !reset;
    assign w_unused_adr = &{1'b0, bus.DataAdr[1:0]};

    always_comb begin
        w_sel = SEL_NONE;
        if (bus.DataAdr[31:AW] == '0) begin
            w_sel = SEL_RAM;
        end else begin
            case (w_word_adr)
                LED_ADR:    w_sel = SEL_LED;
                COUNT_ADR:  w_sel = SEL_COUNT;
                CMP_ADR:    w_sel = SEL_CMP;
                STATUS_ADR: w_sel = SEL_STATUS;
                default:    w_sel = SEL_NONE;
            endcase
        end
    end

    // RAM contents survive reset; only stores outside reset reach the array.
    always_ff @(posedge clk) begin
        if (w_wr && (w_sel == SEL_RAM)) begin
            r_ram[w_ram_idx] <= bus.WriteData;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_led <= '0;
        end else if (w_wr && (w_sel == SEL_LED)) begin
            r_led <= bus.WriteData[7:0];
        end
    end

    mmio_timer #(
        .PRESCALE (PRESCALE)
    ) u_timer (
        .clk       (clk),
        .rst       (reset),
        .we_count  (w_wr && (w_sel == SEL_COUNT)),
        .we_cmp    (w_wr && (w_sel == SEL_CMP)),
        .we_status (w_wr && (w_sel == SEL_STATUS)),
        .wdata     (bus.WriteData),
        .count     (w_count),
        .cmp       (w_cmp),
        .en        (w_en),
        .match     (w_match)
    );

    always_comb begin
        w_status           = '0;
        w_status[ST_MATCH] = w_match;
        w_status[ST_EN]    = w_en;
    end

    always_comb begin
        bus.ReadData = '0;
        case (w_sel)
            SEL_RAM:    bus.ReadData = r_ram[w_ram_idx];
            SEL_LED:    bus.ReadData = {24'h0, r_led};
            SEL_COUNT:  bus.ReadData = w_count;
            SEL_CMP:    bus.ReadData = w_cmp;
            SEL_STATUS: bus.ReadData = w_status;
            default:    bus.ReadData = '0;
        endcase
    end

    assign Leds     = r_led;
    assign TimerIrq = w_match;

endmodule
`default_nettype wire
